router_1xn: RTL and testbench
=============================

# router_1xn

Parametrised 1-to-N packet router, the successor of the fixed 1x3 router. It accepts length-prefixed byte packets on a single input port and steers each packet into one of NUM_CH output FIFOs, selected by the address field of the header. Compared with the 1x3 design it adds:
- configurable channel count, data width, FIFO depth and soft-reset timeout;
- a busy/valid input handshake;
- dropping of packets with an invalid address;
- flushing of a channel's in-flight packet on soft reset.

## Interface
- NUM_CH, default 3: number of output channels, 2..16.
- DATA_W, default 8: byte width; must exceed ADDR_W + 1.
- DEPTH, default 16: entries per output FIFO, power of two.
- SOFT_RST_CYC, default 30: consecutive unread cycles before a channel is flushed.
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- pkt_valid  in  1  data_in holds a packet byte.
- data_in  in  DATA_W  packet byte.
- rd_en  in  NUM_CH  per-channel pop request.
- valid_out  out  NUM_CH  per-channel FIFO not empty.
- data_out  out  NUM_CH*DATA_W  per-channel FIFO head; channel i occupies bits [i*DATA_W +: DATA_W].
- busy  out  1  router cannot accept the byte this cycle.
- error  out  1  parity mismatch on the last completed packet.

## Operation
- ADDR_W = clog2(NUM_CH). LEN_W = DATA_W - ADDR_W.
- Header fields: addr = header[ADDR_W-1:0]; payload length L = header[DATA_W-1:ADDR_W]. L = 0 is legal.
- Packet = header, L payload bytes, parity byte.
- Parity byte = XOR of the header and all payload bytes.
- A byte is accepted on a rising edge where pkt_valid=1 and busy=0. While busy=1 the sender holds data_in.
- FSM states:
  - IDLE: busy = (addr < NUM_CH) && full[addr].
    - Accepted header with a valid addr: write it, latch the channel, load the counter with L, go to PAYLOAD.
    - Accepted header with addr >= NUM_CH: load the counter with L, go to DROP.
  - PAYLOAD: busy = full[ch]. Each accepted byte is written and decrements the counter. When the counter is 0, the next accepted byte is the parity byte: it is written and compared, and the FSM goes to IDLE.
  - DROP: busy=0. Accepted bytes are discarded; the counter runs as in PAYLOAD. The parity byte returns the FSM to IDLE. error is not updated.
- error is set on the edge that accepts a mismatching parity byte, cleared on the edge that accepts the next header, and otherwise held.
- FIFO behaviour:
  - Show-ahead: data_out[i] is the head entry, or 0 when empty. valid_out[i] = !empty[i].
  - A pop occurs on an edge with rd_en[i] && valid_out[i]. rd_en on an empty FIFO is ignored.
  - Read and write in the same cycle are both performed. Write eligibility uses full as sampled at the start of the cycle, so a simultaneous pop does not un-block a write.
- Soft reset, per channel:
  - The counter increments each cycle with valid_out[i] && !rd_en[i], and clears otherwise.
  - On the edge where the counter reaches SOFT_RST_CYC, the FIFO pointers clear and the counter clears.
  - If that edge also accepts a byte for channel i, the byte is discarded.
  - If the FSM is in PAYLOAD on channel i after that edge, it goes to DROP for the remainder of the packet. If the discarded byte was the parity byte, it goes to IDLE.

## Timing
- Reset values: valid_out=0, data_out=0, busy=0, error=0; FSM in IDLE; all counters 0.
- rstn=0 mid-packet aborts the packet and clears all FIFOs on that edge. The sender restarts with a new header.
- Write latency: a byte accepted at edge k is visible on data_out and valid_out after edge k. busy is combinational from state and full.
- Minimum packet duration is L+2 cycles when no stall occurs. Back-to-back packets are allowed; the next header may be accepted on the cycle after the parity byte.

## Configuration
- ROUTER_1XN_PARITY_EN defined: packet format and checking as above.
- ROUTER_1XN_PARITY_EN undefined:
  - No parity byte; the packet ends after L payload bytes.
  - The FSM returns to IDLE after the last payload byte; with L = 0 it stays in IDLE after the header.
  - error is tied 0.

## Structure
- Package router_pkg holds:
  - the state_t enum (IDLE, PAYLOAD, DROP);
  - the clog2-based ADDR_W/LEN_W helper functions;
  - header field extraction functions.
- Sub-module router_fifo: one per channel via generate. It contains the show-ahead FIFO, flush input and soft-reset timeout counter, with parameters DATA_W, DEPTH and SOFT_RST_CYC.
- Top level: FSM, payload counter, parity accumulator, error register and channel decode.

## Test plan
All cases use defaults and ROUTER_1XN_PARITY_EN defined.
- Normal packet: send 0x11, 0x01, 0x02, 0x03, 0x04, 0x15 → channel 1 outputs the 6 bytes in order; error=0; busy stays 0.
- Bad parity: same packet with parity 0x00 → error=1 from the edge after the parity byte is accepted until the next header is accepted.
- Invalid address: header 0x0B (L=2, addr 3), 2 payload bytes, parity → all 4 bytes discarded; valid_out=3'b000; busy=0 throughout.
- Back-pressure: header 0x50 (L=20, ch0) with no reads → busy=1 after 16 bytes are accepted. One rd_en[0] pulse → exactly one more byte accepted.
- Soft reset: load 3 bytes into ch2 and hold rd_en=0 → valid_out[2] falls after the 30th unread edge. The rest of the in-flight packet is dropped; the next packet to ch2 is delivered intact.
- Mid-packet reset: rstn=0 for 1 cycle after 3 bytes of an L=8 packet → all outputs return to reset values; the following packet routes correctly.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared types and helpers for the 1-to-N packet router.
// FSM state codes, field-width helpers and header field extraction.
package router_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE    = 2'd0;
   localparam state_t PAYLOAD = 2'd1;
   localparam state_t DROP    = 2'd2;

   // Width of the address field for a given channel count.
   function automatic int unsigned addr_w(input int unsigned num_ch);
      return $clog2(num_ch);
   endfunction

   // Width of the length field: whatever the address leaves in the header byte.
   function automatic int unsigned len_w(input int unsigned num_ch, input int unsigned data_w);
      return data_w - addr_w(num_ch);
   endfunction

   // Address field, zero-extended; caller truncates to ADDR_W.
   function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int unsigned aw);
      return hdr & ((32'd1 << aw) - 32'd1);
   endfunction

   // Length field, zero-extended; caller truncates to LEN_W.
   function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int unsigned aw);
      return hdr >> aw;
   endfunction

endpackage

// File: rtl/router_1xn_if.sv
// router_1xn_if: packet input handshake and per-channel output bus.
// master = packet source / channel reader, slave = router.
interface router_1xn_if #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned DATA_W = 8
);
   logic                       pkt_valid;
   logic [DATA_W-1:0]          data_in;
   logic [NUM_CH-1:0]          rd_en;
   logic [NUM_CH-1:0]          valid_out;
   logic [NUM_CH*DATA_W-1:0]   data_out;
   logic                       busy;
   logic                       error;

   modport master (
      output pkt_valid, data_in, rd_en,
      input  valid_out, data_out, busy, error
   );

   modport slave (
      input  pkt_valid, data_in, rd_en,
      output valid_out, data_out, busy, error
   );
endinterface

// File: rtl/router_fifo.sv
// router_fifo: show-ahead channel FIFO with an unread-timeout flush.
// o_flush marks the edge on which the timeout empties the FIFO.
module router_fifo #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned SOFT_RST_CYC = 30
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_rd,
   output logic              o_full,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_flush
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned TMO_W = $clog2(SOFT_RST_CYC + 1);

   logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [TMO_W-1:0]  r_tmo;
   logic              w_empty, w_full, w_push, w_pop, w_stall, w_flush;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_stall = !w_empty && !i_rd;
   assign w_flush = w_stall && (r_tmo == TMO_W'(SOFT_RST_CYC - 1));
   // A byte arriving on the flush edge is discarded along with the contents.
   assign w_push  = i_wr && !w_full && !w_flush;
   assign w_pop   = i_rd && !w_empty;

   assign o_full  = w_full;
   assign o_valid = !w_empty;
   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
   assign o_flush = w_flush;

   // Pointer and timeout state; flush clears both.
   always_ff @(posedge clk) begin
      if (!rstn || w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_tmo    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W + 1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1);
         r_tmo <= w_stall ? r_tmo + TMO_W'(1) : '0;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
   end
endmodule

// File: rtl/router_1xn.sv
// router_1xn: parametrised 1-to-N length-prefixed packet router.
// Define ROUTER_1XN_PARITY_EN to add a trailing parity byte and the error flag.
module router_1xn
   import router_pkg::*;
#(
   parameter int unsigned NUM_CH       = 3,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned SOFT_RST_CYC = 30
) (
   input logic         clk,
   input logic         rstn,
   router_1xn_if.slave bus
);
   localparam int unsigned ADDR_W = addr_w(NUM_CH);
   localparam int unsigned LEN_W  = len_w(NUM_CH, DATA_W);
   localparam int unsigned PAD_N  = 1 << ADDR_W;

   state_t                   r_state, w_state_nxt;
   logic [ADDR_W-1:0]        r_ch, w_ch_nxt, w_wr_ch, w_hdr_addr;
   logic [LEN_W-1:0]         r_cnt, w_cnt_nxt, w_hdr_len;
   logic                     w_addr_ok, w_busy, w_accept, w_wr_en;
   logic [NUM_CH-1:0]        w_full, w_flush, w_wr, w_valid;
   logic [NUM_CH*DATA_W-1:0] w_data;
   logic [PAD_N-1:0]         w_full_pad, w_flush_pad;

   assign w_hdr_addr = ADDR_W'(hdr_addr(32'(bus.data_in), ADDR_W));
   assign w_hdr_len  = LEN_W'(hdr_len(32'(bus.data_in), ADDR_W));
   assign w_addr_ok  = (32'(w_hdr_addr) < NUM_CH);

   // Widen per-channel flags so any address value indexes safely.
   always_comb begin
      w_full_pad                = '0;
      w_flush_pad               = '0;
      w_full_pad[NUM_CH-1:0]    = w_full;
      w_flush_pad[NUM_CH-1:0]   = w_flush;
   end

   // Back-pressure from the target channel; dropped packets never stall.
   always_comb begin
      w_busy = 1'b0;
      case (r_state)
         IDLE:    w_busy = w_addr_ok && w_full_pad[w_hdr_addr];
         PAYLOAD: w_busy = w_full_pad[r_ch];
         default: w_busy = 1'b0;
      endcase
   end

   assign w_accept = bus.pkt_valid && !w_busy;
   assign bus.busy = w_busy;

`ifdef ROUTER_1XN_PARITY_EN
   logic w_par_chk;
`endif

   // Packet sequencing: header decode, byte counting, channel write select.
   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      w_cnt_nxt   = r_cnt;
      w_wr_en     = 1'b0;
      w_wr_ch     = r_ch;
`ifdef ROUTER_1XN_PARITY_EN
      w_par_chk   = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_cnt_nxt = w_hdr_len;
               if (w_addr_ok) begin
                  w_wr_en     = 1'b1;
                  w_wr_ch     = w_hdr_addr;
                  w_ch_nxt    = w_hdr_addr;
                  w_state_nxt = PAYLOAD;
               end else begin
                  w_state_nxt = DROP;
               end
`ifndef ROUTER_1XN_PARITY_EN
               // Header-only packet: nothing follows.
               if (w_hdr_len == '0) w_state_nxt = IDLE;
`endif
            end
         end
         PAYLOAD, DROP: begin
            if (w_accept) begin
               w_wr_en = (r_state == PAYLOAD);
`ifdef ROUTER_1XN_PARITY_EN
               // Counter at zero means this byte is the parity byte.
               if (r_cnt == '0) begin
                  w_state_nxt = IDLE;
                  w_par_chk   = (r_state == PAYLOAD);
               end else begin
                  w_cnt_nxt = r_cnt - LEN_W'(1);
               end
`else
               w_cnt_nxt = r_cnt - LEN_W'(1);
               if (r_cnt == LEN_W'(1)) w_state_nxt = IDLE;
`endif
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // A channel flushed under an in-flight packet loses the rest of it.
      if (w_state_nxt == PAYLOAD && w_flush_pad[w_ch_nxt]) w_state_nxt = DROP;
   end

   // FSM, channel and length counter registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_ch    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

`ifdef ROUTER_1XN_PARITY_EN
   logic [DATA_W-1:0] r_par;
   logic              r_err;

   // Running XOR over header and payload; error updates only on checked parity.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_par <= '0;
         r_err <= 1'b0;
      end else if (w_accept) begin
         if (r_state == IDLE) begin
            r_par <= bus.data_in;
            r_err <= 1'b0;
         end else if (w_par_chk) begin
            r_err <= (bus.data_in != r_par);
         end else begin
            r_par <= r_par ^ bus.data_in;
         end
      end
   end

   assign bus.error = r_err;
`else
   assign bus.error = 1'b0;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_wr[g] = w_accept && w_wr_en && (w_wr_ch == ADDR_W'(g));

      router_fifo #(
         .DATA_W       (DATA_W),
         .DEPTH        (DEPTH),
         .SOFT_RST_CYC (SOFT_RST_CYC)
      ) u_fifo (
         .clk     (clk),
         .rstn    (rstn),
         .i_wr    (w_wr[g]),
         .i_data  (bus.data_in),
         .i_rd    (bus.rd_en[g]),
         .o_full  (w_full[g]),
         .o_valid (w_valid[g]),
         .o_data  (w_data[g*DATA_W +: DATA_W]),
         .o_flush (w_flush[g])
      );
   end

   assign bus.valid_out = w_valid;
   assign bus.data_out  = w_data;
endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: scoreboard bench for router_1xn at default parameters.
// Adapts packet format to ROUTER_1XN_PARITY_EN.
module tb_router_1xn;
   localparam int unsigned NUM_CH = 3;
   localparam int unsigned DATA_W = 8;
`ifdef ROUTER_1XN_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_acc = 0;
   int   cur_ch = -1;
   bit   busy_seen = 1'b0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];

   router_1xn_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

   router_1xn #(
      .NUM_CH       (NUM_CH),
      .DATA_W       (DATA_W),
      .DEPTH        (16),
      .SOFT_RST_CYC (30)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input int ch, input logic [7:0] b);
      case (ch)
         0: q0.push_back(b);
         1: q1.push_back(b);
         default: q2.push_back(b);
      endcase
   endtask

   function automatic int exp_size(input int ch);
      case (ch)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic pop_exp(input int ch, output logic [7:0] b);
      case (ch)
         0: b = q0.pop_front();
         1: b = q1.pop_front();
         default: b = q2.pop_front();
      endcase
   endtask

   // One clock: record any byte the router takes on this edge into the scoreboard.
   task automatic tick();
      bit acc;
      #1;
      acc = bus.pkt_valid && !bus.busy;
      if (bus.pkt_valid && bus.busy) busy_seen = 1'b1;
      if (acc) begin
         n_acc++;
         if (cur_ch >= 0) push_exp(cur_ch, bus.data_in);
      end
      @(posedge clk);
      #1;
      if (acc) bus.pkt_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      bus.pkt_valid = 1'b1;
      bus.data_in   = b;
      w = 0;
      #1;
      while (bus.busy && w < 64) begin
         tick();
         w++;
      end
      if (w >= 64) check("accept_timeout", 32'(bus.busy), 32'(0));
      tick();
   endtask

   task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] base, input bit bad);
      logic [7:0] par;
      logic [7:0] b;
      par = hdr;
      send_byte(hdr);
      for (int i = 0; i < int'(hdr[7:2]); i++) begin
         b = base + 8'(i);
         par ^= b;
         send_byte(b);
      end
      if (PAR_EN) send_byte(bad ? 8'h00 : par);
   endtask

   task automatic pop(input int ch, input string tag);
      logic [7:0] e;
      pop_exp(ch, e);
      check({tag, "_vld"}, 32'(bus.valid_out[ch]), 32'(1));
      check({tag, "_dat"}, 32'(bus.data_out[ch*8 +: 8]), 32'(e));
      bus.rd_en[ch] = 1'b1;
      tick();
      bus.rd_en[ch] = 1'b0;
   endtask

   task automatic drain(input int ch, input string tag);
      int guard;
      guard = 0;
      while (exp_size(ch) > 0 && guard < 64) begin
         pop(ch, tag);
         guard++;
      end
      check({tag, "_empty"}, 32'(bus.valid_out[ch]), 32'(0));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_valid_out"}, 32'(bus.valid_out), 32'(0));
      check({tag, "_data_out"},  32'(bus.data_out), 32'(0));
      check({tag, "_busy"},      32'(bus.busy), 32'(0));
      check({tag, "_error"},     32'(bus.error), 32'(0));
   endtask

   initial begin
      int n0;
      bus.pkt_valid = 1'b0;
      bus.data_in   = '0;
      bus.rd_en     = '0;
      repeat (3) tick();
      check_reset_vals("reset");
      rstn = 1'b1;
      tick();

      // Normal packet to channel 1.
      busy_seen = 1'b0;
      cur_ch = 1;
      send_pkt(8'h11, 8'h01, 1'b0);
      check("norm_busy", 32'(busy_seen), 32'(0));
      check("norm_err", 32'(bus.error), 32'(0));
      check("norm_vld", 32'(bus.valid_out), 32'(3'b010));
      drain(1, "norm");

`ifdef ROUTER_1XN_PARITY_EN
      // Bad parity: error from the parity edge until the next header.
      cur_ch = 1;
      send_pkt(8'h11, 8'h01, 1'b1);
      check("bad_err_set", 32'(bus.error), 32'(1));
      drain(1, "bad");
      check("bad_err_hold", 32'(bus.error), 32'(1));
      cur_ch = 2;
      send_byte(8'h02);
      check("bad_err_clr", 32'(bus.error), 32'(0));
      send_byte(8'h02);
      check("l0_err", 32'(bus.error), 32'(0));
      drain(2, "l0");
`endif

      // Invalid address: whole packet discarded.
      busy_seen = 1'b0;
      cur_ch = -1;
      send_pkt(8'h0B, 8'h01, 1'b0);
      check("inv_busy", 32'(busy_seen), 32'(0));
      check("inv_vld", 32'(bus.valid_out), 32'(0));

      // Back-pressure on channel 0.
      cur_ch = 0;
      n0 = n_acc;
      send_byte(8'h50);
      for (int k = 1; k <= 15; k++) send_byte(8'(k));
      check("bp_acc16", 32'(n_acc - n0), 32'(16));
      bus.data_in   = 8'd16;
      bus.pkt_valid = 1'b1;
      #1;
      check("bp_busy_full", 32'(bus.busy), 32'(1));
      tick();
      tick();
      check("bp_busy_hold", 32'(bus.busy), 32'(1));
      n0 = n_acc;
      pop(0, "bp_first");
      check("bp_busy_free", 32'(bus.busy), 32'(0));
      tick();
      bus.data_in   = 8'd17;
      bus.pkt_valid = 1'b1;
      #1;
      check("bp_one_more", 32'(n_acc - n0), 32'(1));
      check("bp_busy_again", 32'(bus.busy), 32'(1));
      drain(0, "bp");
      for (int k = 18; k <= 20; k++) send_byte(8'(k));
      if (PAR_EN) send_byte(8'h44);
      check("bp_err", 32'(bus.error), 32'(0));
      drain(0, "bp_tail");

      // Soft reset: 3 bytes into channel 2, then leave them unread.
      cur_ch = 2;
      send_byte(8'h16);
      send_byte(8'hC1);
      send_byte(8'hC2);
      repeat (27) tick();
      check("srst_before", 32'(bus.valid_out[2]), 32'(1));
      tick();
      check("srst_flush", 32'(bus.valid_out[2]), 32'(0));
      q2.delete();
      busy_seen = 1'b0;
      cur_ch = -1;
      send_byte(8'hC3);
      send_byte(8'hC4);
      send_byte(8'hC5);
      if (PAR_EN) send_byte(8'hD7);
      check("srst_drop_busy", 32'(busy_seen), 32'(0));
      check("srst_drop_vld", 32'(bus.valid_out), 32'(0));
      cur_ch = 2;
      send_pkt(8'h0A, 8'hA1, 1'b0);
      drain(2, "srst_next");

      // Mid-packet synchronous reset.
      cur_ch = 1;
      send_byte(8'h21);
      send_byte(8'h31);
      send_byte(8'h32);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      q0.delete();
      q1.delete();
      q2.delete();
      check_reset_vals("midrst");
      cur_ch = 0;
      send_pkt(8'h08, 8'h5A, 1'b0);
      check("post_rst_vld", 32'(bus.valid_out), 32'(3'b001));
      drain(0, "post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
